// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types for the keypad matrix scanner: frame classification, FSM state
// and the key-code width helper.
package keypad_matrix_scanner_pkg;

    typedef enum logic [1:0] {
        ClsNone,
        ClsSingle,
        ClsMulti
    } frame_cls_e;

    typedef enum logic {
        StIdle,
        StPressed
    } key_state_e;

    function automatic int unsigned code_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_debouncer.sv
// Frame-level debouncer: counts identical consecutive frame classifications and
// flags the frame end at which a run first reaches DEBOUNCE.
module keypad_debouncer
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CODE_W   = 4
) (
    input  logic              scanClock,
    input  logic              resetN,
    input  logic              frame_end_i,
    input  frame_cls_e        cls_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              stable_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    frame_cls_e        prev_cls_q, prev_cls_d;
    logic [CODE_W-1:0] prev_code_q, prev_code_d;
    logic              same;

    always_comb begin
        cnt_d       = cnt_q;
        prev_cls_d  = prev_cls_q;
        prev_code_d = prev_code_q;
        stable_o    = 1'b0;
        // The code only distinguishes runs of SINGLE frames.
        same = (cls_i == prev_cls_q) && ((cls_i != ClsSingle) || (code_i == prev_code_q));
        if (frame_end_i) begin
            if (!same) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            prev_cls_d  = cls_i;
            prev_code_d = code_i;
            // Fire only on reaching the limit, not while sitting saturated.
            stable_o = (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
        end
    end

    always_ff @(posedge scanClock or negedge resetN) begin
        if (!resetN) begin
            cnt_q       <= '0;
            prev_cls_q  <= ClsNone;
            prev_code_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad matrix controller: rotates a one-hot row drive, classifies
// each full frame, debounces it and reports press/release/multi-key events.
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 3,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned CODE_W  = code_width(ROWS * COLS)
) (
    input  logic              scanClock,
    input  logic              resetN,
    output logic [ROWS-1:0]   rowDrivers,
    input  logic [COLS-1:0]   columnReceivers,
    output logic [CODE_W-1:0] keyCode,
    output logic              keyValid,
    output logic              keyRelease,
    output logic              keyHeld,
    output logic              multiKey
);

    localparam logic [ROWS-1:0] ROW_FIRST = ROWS'(1);

    logic [ROWS-1:0]   row_q, row_d;
    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;
    logic              row_onehot, frame_end, stable;
    logic [1:0]        row_cnt, tot;
    logic [2:0]        sum;
    int                row_idx, col_idx;
    logic [CODE_W-1:0] sample_code, frame_code;
    frame_cls_e        cls;

    key_state_e        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d, release_q, release_d, multi_q, multi_d;

    // Scan and frame classification; accumulator saturates at "two or more".
    always_comb begin
        row_onehot = (row_q != '0) && ((row_q & (row_q - ROW_FIRST)) == '0);
        row_d      = row_onehot ? {row_q[ROWS-2:0], row_q[ROWS-1]} : ROW_FIRST;
        frame_end  = row_onehot && row_q[ROWS-1];
        row_idx    = 0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_q[r]) row_idx = r;
        end
        row_cnt = 2'd0;
        col_idx = 0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (columnReceivers[c]) begin
                if (row_cnt == 2'd0) col_idx = c;
                row_cnt = (row_cnt == 2'd0) ? 2'd1 : 2'd2;
            end
        end
        sum         = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
        tot         = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        sample_code = CODE_W'(row_idx * int'(COLS) + col_idx);
        frame_code  = (acc_cnt_q == 2'd0) ? sample_code : acc_code_q;
        cls         = (tot == 2'd0) ? ClsNone : ((tot == 2'd1) ? ClsSingle : ClsMulti);
        if (frame_end || !row_onehot) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = '0;
        end else begin
            acc_cnt_d  = tot;
            acc_code_d = frame_code;
        end
    end

    keypad_debouncer #(
        .DEBOUNCE (DEBOUNCE),
        .CODE_W   (CODE_W)
    ) u_debouncer (
        .scanClock   (scanClock),
        .resetN      (resetN),
        .frame_end_i (frame_end),
        .cls_i       (cls),
        .code_i      (frame_code),
        .stable_o    (stable)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        release_d = 1'b0;
        multi_d   = multi_q;
        if (frame_end && (cls != ClsMulti)) multi_d = 1'b0;
        if (stable) begin
            case (cls)
                ClsSingle: begin
                    // A different key while pressed is ignored until release.
                    if (state_q == StIdle) begin
                        code_d  = frame_code;
                        valid_d = 1'b1;
                        state_d = StPressed;
                    end
                end
                ClsNone: begin
                    if (state_q == StPressed) begin
                        release_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                ClsMulti: multi_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge scanClock or negedge resetN) begin
        if (!resetN) begin
            row_q      <= ROW_FIRST;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
            state_q    <= StIdle;
            code_q     <= '0;
            valid_q    <= 1'b0;
            release_q  <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            row_q      <= row_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            release_q  <= release_d;
            multi_q    <= multi_d;
        end
    end

    assign rowDrivers = row_q;
    assign keyCode    = code_q;
    assign keyValid   = valid_q;
    assign keyRelease = release_q;
    assign keyHeld    = (state_q == StPressed);
    assign multiKey   = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboarded bench for keypad_matrix_scanner: a 4x3 instance checked through an
// event queue plus direct level checks, and a 4x4 instance for mid-frame reset.
module tb_keypad_matrix_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4x3 instance
    logic             resetN_a;
    logic [3:0]       rows_a;
    logic [2:0]       cols_a;
    logic [3:0]       code_a;
    logic             valid_a, release_a, held_a, multi_a;
    logic [3:0][2:0]  keys_a;

    // 4x4 instance
    logic             resetN_b;
    logic [3:0]       rows_b;
    logic [3:0]       cols_b;
    logic [3:0]       code_b;
    logic             valid_b, release_b, held_b, multi_b;
    logic [3:0][3:0]  keys_b;

    keypad_matrix_scanner #(.ROWS(4), .COLS(3), .DEBOUNCE(3)) dut_a (
        .scanClock       (clk),
        .resetN          (resetN_a),
        .rowDrivers      (rows_a),
        .columnReceivers (cols_a),
        .keyCode         (code_a),
        .keyValid        (valid_a),
        .keyRelease      (release_a),
        .keyHeld         (held_a),
        .multiKey        (multi_a)
    );

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .DEBOUNCE(3)) dut_b (
        .scanClock       (clk),
        .resetN          (resetN_b),
        .rowDrivers      (rows_b),
        .columnReceivers (cols_b),
        .keyCode         (code_b),
        .keyValid        (valid_b),
        .keyRelease      (release_b),
        .keyHeld         (held_b),
        .multiKey        (multi_b)
    );

    // Keypad model: a pressed key connects its row driver to its column.
    always_comb begin
        cols_a = '0;
        cols_b = '0;
        for (int r = 0; r < 4; r++) begin
            if (rows_a[r]) cols_a = cols_a | keys_a[r];
            if (rows_b[r]) cols_b = cols_b | keys_b[r];
        end
    end

    int checks = 0;
    int passed = 0;
    int nvalid = 0;
    int cyc;

    typedef struct {
        bit         is_release;
        logic [3:0] code;
        int         cyc;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges since instance A left reset; the edge that samples row 0 first is 1.
    always @(posedge clk or negedge resetN_a) begin
        if (!resetN_a) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: every pulse on instance A must match the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        if (resetN_a === 1'b1) begin
            if (valid_a && release_a) check("valid_release_exclusive", 32'd1, 32'd0);
            if (valid_a) nvalid++;
            if (valid_a || release_a) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, valid_a, release_a}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, release_a}, {31'd0, e.is_release});
                    check("pulse_code", {28'd0, code_a}, {28'd0, e.code});
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        resetN_a = 1'b0;
        resetN_b = 1'b0;
        keys_a   = '0;
        keys_b   = '0;
        clocks(3);
        check("rst_rows", {28'd0, rows_a}, 32'd1);
        check("rst_outputs", {24'd0, code_a, valid_a, release_a, held_a, multi_a}, 32'd0);

        // Idle scan sequence
        @(negedge clk);
        resetN_a = 1'b1;
        check("rows_seq0", {28'd0, rows_a}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            clocks(1);
            check($sformatf("rows_seq%0d", i), {28'd0, rows_a}, 32'd1 << (i % 4));
        end
        check("idle_outputs", {24'd0, code_a, valid_a, release_a, held_a, multi_a}, 32'd0);

        // Press row 2 col 1 from a frame start: code 7 after 12 clocks
        keys_a[2][1] = 1'b1;
        exp_q.push_back('{1'b0, 4'd7, cyc + 12});
        clocks(11);
        check("held_before_latency", {31'd0, held_a}, 32'd0);
        clocks(1);
        check("press_held", {31'd0, held_a}, 32'd1);
        check("press_code", {28'd0, code_a}, 32'd7);

        // Release for 3 frames
        keys_a = '0;
        exp_q.push_back('{1'b1, 4'd7, cyc + 12});
        clocks(12);
        check("release_held", {31'd0, held_a}, 32'd0);
        check("release_code_holds", {28'd0, code_a}, 32'd7);

        // Bounce: 2 frames pressed, 1 released, 2 pressed -> no press accepted
        keys_a[2][1] = 1'b1;
        clocks(8);
        keys_a = '0;
        clocks(4);
        keys_a[2][1] = 1'b1;
        clocks(8);
        keys_a = '0;
        clocks(12);
        check("bounce_held", {31'd0, held_a}, 32'd0);
        check("bounce_valid_count", nvalid, 32'd1);

        // Two keys for 3 frames -> multiKey, no press
        keys_a[0][0] = 1'b1;
        keys_a[3][2] = 1'b1;
        clocks(11);
        check("multi_before_stable", {31'd0, multi_a}, 32'd0);
        clocks(1);
        check("multi_set", {31'd0, multi_a}, 32'd1);
        check("multi_not_held", {31'd0, held_a}, 32'd0);
        keys_a = '0;
        clocks(3);
        check("multi_until_frame_end", {31'd0, multi_a}, 32'd1);
        clocks(1);
        check("multi_cleared", {31'd0, multi_a}, 32'd0);

        // A second key while pressed is ignored until release
        keys_a[1][0] = 1'b1;
        exp_q.push_back('{1'b0, 4'd3, cyc + 12});
        clocks(12);
        check("press2_code", {28'd0, code_a}, 32'd3);
        keys_a = '0;
        keys_a[2][2] = 1'b1;
        clocks(12);
        check("other_key_code", {28'd0, code_a}, 32'd3);
        check("other_key_held", {31'd0, held_a}, 32'd1);
        keys_a = '0;
        exp_q.push_back('{1'b1, 4'd3, cyc + 12});
        clocks(12);
        check("release2_held", {31'd0, held_a}, 32'd0);
        clocks(2);
        check("events_pending", exp_q.size(), 32'd0);
        check("total_valid_count", nvalid, 32'd2);

        // 4x4: reset mid-frame while row 3 col 3 is held
        @(negedge clk);
        resetN_b = 1'b1;
        keys_b[3][3] = 1'b1;
        clocks(6);
        resetN_b = 1'b0;
        #1;
        check("b_rst_rows", {28'd0, rows_b}, 32'd1);
        check("b_rst_outputs", {24'd0, code_b, valid_b, release_b, held_b, multi_b}, 32'd0);
        clocks(2);
        check("b_rst_rows_held", {28'd0, rows_b}, 32'd1);
        @(negedge clk);
        resetN_b = 1'b1;
        clocks(1);
        check("b_restart_row1", {28'd0, rows_b}, 32'd2);
        clocks(10);
        check("b_no_early_valid", {31'd0, valid_b}, 32'd0);
        clocks(1);
        check("b_valid", {31'd0, valid_b}, 32'd1);
        check("b_code", {28'd0, code_b}, 32'd15);
        check("b_held", {31'd0, held_b}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of row drivers; SHALL be at least 2.
REQ-002 Parameter COLS, default 3: number of column receivers; SHALL be at least 1.
REQ-003 Parameter DEBOUNCE, default 3: number of identical consecutive frames required before a result is accepted; SHALL be at least 1.
REQ-004 Derived constant CODE_W SHALL equal max(1, clog2(ROWS*COLS)).
REQ-005 Port scanClock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port rowDrivers, output, ROWS bits: one-hot row drive, registered.
REQ-008 Port columnReceivers, input, COLS bits: active-high column sense, already synchronised externally.
REQ-009 Port keyCode, output, CODE_W bits: code of the accepted key, computed as row*COLS + col (0-based).
REQ-010 Port keyValid, output, 1 bit: one-cycle pulse when a new key press is accepted.
REQ-011 Port keyRelease, output, 1 bit: one-cycle pulse when the accepted key is released.
REQ-012 Port keyHeld, output, 1 bit: level, high while in state PRESSED.
REQ-013 Port multiKey, output, 1 bit: level, high while a debounced multi-key frame is current.

Function
REQ-014 rowDrivers SHALL rotate one position per clock, from bit 0 up to bit ROWS-1 and then back to bit 0; any non-one-hot value SHALL be forced to bit 0 on the next clock.
REQ-015 On each edge, columnReceivers SHALL be sampled as belonging to the row currently driven.
- One frame = ROWS consecutive samples, from row 0 through row ROWS-1.
REQ-016 Each frame SHALL be classified as follows:
- NONE: no column bits set.
- SINGLE(code): exactly one bit set across the whole frame.
- MULTI: two or more bits set, in any rows or columns.
REQ-017 Classification SHALL complete on the edge that samples row ROWS-1; the debounce logic SHALL update on that same edge.
REQ-018 Debounce counter handling at each frame end:
- If the classification equals the previous frame's classification (including the code), the counter SHALL increment and saturate at DEBOUNCE.
- Otherwise the counter SHALL load 1.
- Counter width SHALL be clog2(DEBOUNCE+1).
REQ-019 A classification is "stable" at the frame end where the counter reaches DEBOUNCE; stable actions SHALL fire once per run, not on every saturated frame.
REQ-020 FSM states IDLE and PRESSED; transitions:
- IDLE + stable SINGLE(c): set keyCode to c, pulse keyValid, go to PRESSED.
- PRESSED + stable NONE: pulse keyRelease, go to IDLE, keyCode holds.
- PRESSED + stable SINGLE(d) with d different from keyCode: ignore and stay PRESSED; the key must be released first.
- Stable MULTI in either state: set multiKey, no keyValid, state unchanged.
REQ-021 multiKey SHALL clear at the next frame end whose classification is not MULTI.
REQ-022 keyValid and keyRelease SHALL assert in the cycle after the frame-end edge and SHALL never assert together.
REQ-023 Press latency: a key held from a frame start SHALL raise keyValid exactly DEBOUNCE*ROWS clocks after that frame's first sample.
REQ-024 Bounce: any frame that differs from the current run SHALL restart the count, so no pulse occurs until DEBOUNCE new identical frames have been seen.

Reset
REQ-025 While resetN is low:
- rowDrivers SHALL be one-hot at bit 0.
- keyCode, keyValid, keyRelease, keyHeld and multiKey SHALL be 0.
- The FSM SHALL be in IDLE.
- The debounce counter and frame accumulator SHALL be cleared.
- The previous classification SHALL be NONE.
REQ-026 Assertion of reset in the middle of a frame SHALL discard the partial frame; scanning SHALL restart at row 0 on the first clock after release.

Structure
REQ-027 A shared package SHALL hold:
- the frame-classification enum NONE/SINGLE/MULTI;
- the FSM state enum IDLE/PRESSED;
- the CODE_W derivation function.
REQ-028 One sub-module, keypad_debouncer, SHALL hold the counter, the previous-classification register and the stable detect; the row rotation, frame classifier and FSM SHALL remain in the top module.

Verification
REQ-029 The bench SHALL cover the following directed scenarios, with ROWS=4, COLS=3, DEBOUNCE=3 unless stated otherwise:
- Reset, then 4 idle clocks -> rowDrivers sequence 0001,0010,0100,1000,0001; all outputs 0.
- Hold row 2 col 1 from a frame start -> keyValid pulses once after 12 clocks, keyCode=7, keyHeld=1.
- Press row 2 col 1 for 2 frames, release for 1 frame, press for 2 frames -> no keyValid.
- Hold row 0 col 0 and row 3 col 2 for 3 frames -> multiKey=1, keyValid never asserted; release both -> multiKey=0 after the next frame.
- After an accepted press, release for 3 frames -> keyRelease pulses once, keyHeld=0, keyCode holds 7.
- ROWS=4, COLS=4: hold row 3 col 3, then assert resetN low mid-frame and release it -> outputs cleared, rowDrivers=0001, scan restarts; after 3 further frames keyCode=15.
